clock_set_ctrl: RTL and testbench

Mode sequencer for the alarm-clock datapath. Turns two physical buttons (Mode, Adv) into the timeset/alarmset levels and the one-shot advance enables that drive the minute, hour, day, date and month counters and the alarm minute/hour registers. Sits between the button pins and the counter/display top level, in the same clock domain. The counters see each advance as a single-cycle enable qualified by clk.

---
 rtl/clock_set_ctrl.sv | 172 +++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: turns the Mode and Adv buttons into set-mode levels and
// single-cycle advance enables for the alarm-clock counters.
//
//  state     | meaning
//  RUN       | normal timekeeping, Adv ignored
//  SET_MIN   | setting time minutes   (Adv -> minadv)
//  SET_HRS   | setting time hours     (Adv -> hrsadv)
//  SET_DAY   | setting day of week    (Adv -> dayadv)
//  SET_DATE  | setting date           (Adv -> dateadv)
//  SET_MONTH | setting month          (Adv -> monthadv)
//  ALM_MIN   | setting alarm minutes  (Adv -> minadv)
//  ALM_HRS   | setting alarm hours    (Adv -> hrsadv)
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT = 10,
    parameter int unsigned HOLD    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       adv_btn,
    output logic       timeset,
    output logic       alarmset,
    output logic       minadv,
    output logic       hrsadv,
    output logic       dayadv,
    output logic       dateadv,
    output logic       monthadv,
    output logic [2:0] field
);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_MIN   = 3'd1,
        SET_HRS   = 3'd2,
        SET_DAY   = 3'd3,
        SET_DATE  = 3'd4,
        SET_MONTH = 3'd5,
        ALM_MIN   = 3'd6,
        ALM_HRS   = 3'd7
    } state_t;

    localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);
    localparam logic [3:0] HOLD_C    = 4'(HOLD);

    state_t     state;
    state_t     state_n;
    logic [2:0] mode_sync;
    logic [2:0] adv_sync;
    logic       mode_prev;
    logic       adv_prev;
    logic       adv_live;
    logic [2:0] warm;
    logic [3:0] idle_cnt;
    logic [3:0] idle_n;
    logic [3:0] hold_cnt;
    logic [3:0] hold_n;
    logic [4:0] pulse_q;
    logic [4:0] pulse_n;
    logic [4:0] adv_sel;
    logic       prev_valid;
    logic       mode_ev;
    logic       adv_ev;
    logic       adv_held;
    logic       in_set;
    logic       timeout_hit;
    logic       repeat_hit;
    logic       rep_fire;

    // Synchronise both buttons, keep the edge-detect history, and track
    // whether the current Adv hold began with a genuine press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync <= '0;
            adv_sync  <= '0;
            mode_prev <= 1'b0;
            adv_prev  <= 1'b0;
            warm      <= '0;
            adv_live  <= 1'b0;
        end else begin
            mode_sync <= {mode_sync[1:0], mode_btn};
            adv_sync  <= {adv_sync[1:0], adv_btn};
            mode_prev <= mode_sync[2];
            adv_prev  <= adv_sync[2];
            warm      <= (warm == 3'd4) ? warm : warm + 3'd1;
            adv_live  <= adv_ev | (adv_live & adv_sync[2]);
        end
    end

    // The prev flop only holds a real sample four edges after reset; until
    // then its reset zero would turn a button held through reset into a press.
    assign prev_valid  = (warm == 3'd4);
    assign mode_ev     = mode_sync[2] & ~mode_prev & prev_valid;
    assign adv_ev      = adv_sync[2] & ~adv_prev & prev_valid;
    assign adv_held    = adv_live & adv_sync[2];
    assign in_set      = (state != RUN);
    assign timeout_hit = tick & in_set & ((idle_cnt + 4'd1) == TIMEOUT_C);
    assign repeat_hit  = tick & in_set & adv_held & (hold_cnt == HOLD_C);

    // Map the current state to the advance output it drives.
    always_comb begin
        adv_sel = 5'b00000;
        case (state)
            SET_MIN, ALM_MIN: adv_sel = 5'b00001;
            SET_HRS, ALM_HRS: adv_sel = 5'b00010;
            SET_DAY:          adv_sel = 5'b00100;
            SET_DATE:         adv_sel = 5'b01000;
            SET_MONTH:        adv_sel = 5'b10000;
            default:          adv_sel = 5'b00000;
        endcase
    end

    // State, counters and registered advance pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            idle_cnt <= '0;
            hold_cnt <= '0;
            pulse_q  <= '0;
        end else begin
            state    <= state_n;
            idle_cnt <= idle_n;
            hold_cnt <= hold_n;
            pulse_q  <= pulse_n;
        end
    end

    // Next state with priority Mode > Adv press > timeout > auto-repeat.
    always_comb begin
        state_n  = state;
        pulse_n  = 5'b00000;
        idle_n   = idle_cnt;
        hold_n   = hold_cnt;
        rep_fire = 1'b0;

        if (mode_ev) begin
            state_n = state_t'(state + 3'd1);
        end else if (adv_ev && in_set) begin
            pulse_n = adv_sel;
        end else if (timeout_hit) begin
            state_n = RUN;
        end else if (repeat_hit) begin
            pulse_n  = adv_sel;
            rep_fire = 1'b1;
        end

        if (mode_ev || adv_ev || rep_fire || (state_n == RUN)) begin
            idle_n = '0;
        end else if (tick && in_set) begin
            idle_n = idle_cnt + 4'd1;
        end

        if (!adv_held || adv_ev || (state_n != state)) begin
            hold_n = '0;
        end else if (tick && in_set && (hold_cnt != HOLD_C)) begin
            hold_n = hold_cnt + 4'd1;
        end
    end

    // Levels decoded from the registered state so they settle before any pulse.
    always_comb begin
        field    = state;
        timeset  = (state >= SET_MIN) && (state <= SET_MONTH);
        alarmset = (state == ALM_MIN) || (state == ALM_HRS);
        minadv   = pulse_q[0];
        hrsadv   = pulse_q[1];
        dayadv   = pulse_q[2];
        dateadv  = pulse_q[3];
        monthadv = pulse_q[4];
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: vector table, directed corner sequences and a
// randomized run against a behavioural model.
module tb_clock_set_ctrl;

    localparam int TIMEOUT = 10;
    localparam int HOLD    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       mode_btn = 1'b0;
    logic       adv_btn = 1'b0;
    logic       timeset, alarmset;
    logic       minadv, hrsadv, dayadv, dateadv, monthadv;
    logic [2:0] field;

    int errors = 0;
    int checks = 0;

    clock_set_ctrl #(.TIMEOUT(TIMEOUT), .HOLD(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .mode_btn (mode_btn),
        .adv_btn  (adv_btn),
        .timeset  (timeset),
        .alarmset (alarmset),
        .minadv   (minadv),
        .hrsadv   (hrsadv),
        .dayadv   (dayadv),
        .dateadv  (dateadv),
        .monthadv (monthadv),
        .field    (field)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int       sel_of [8] = '{-1, 0, 1, 2, 3, 4, 0, 1};
    int       m_st, m_idle, m_hold, m_edges, m_pulse;
    bit       m_valid;
    bit [4:0] m_mh, m_ah;

    int       cnt [5];

    typedef struct {
        int       n_mode;
        int       fld;
        bit       ts;
        bit       as;
        bit [4:0] mask;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_idle = 0; m_hold = 0; m_edges = 0; m_pulse = -1;
        m_valid = 1'b0; m_mh = '0; m_ah = '0;
    endtask

    // One rising edge of the reference model, using the inputs present at the edge.
    task automatic model_step();
        bit mev, aev, held, in_set, to, rep;
        int nst, pulse;
        m_edges++;
        m_mh = {m_mh[3:0], mode_btn};
        m_ah = {m_ah[3:0], adv_btn};
        // a press is a high sample three edges ago following a real low before it
        mev    = (m_edges >= 5) && m_mh[3] && !m_mh[4];
        aev    = (m_edges >= 5) && m_ah[3] && !m_ah[4];
        held   = m_valid && m_ah[3];
        in_set = (m_st != 0);
        to     = in_set && tick && (m_idle + 1 == TIMEOUT);
        rep    = in_set && tick && held && (m_hold == HOLD);
        nst    = m_st;
        pulse  = -1;
        if (mev)                 nst = (m_st + 1) % 8;
        else if (aev && in_set)  pulse = sel_of[m_st];
        else if (to)             nst = 0;
        else if (rep)            pulse = sel_of[m_st];
        if (mev || aev || pulse >= 0 || nst == 0) m_idle = 0;
        else if (tick && in_set)                   m_idle = m_idle + 1;
        if (!held || aev || nst != m_st)                m_hold = 0;
        else if (tick && in_set && m_hold < HOLD)       m_hold = m_hold + 1;
        m_valid = aev ? 1'b1 : (m_ah[3] ? m_valid : 1'b0);
        m_st    = nst;
        m_pulse = pulse;
    endtask

    function automatic logic [4:0] dut_adv();
        return {monthadv, dateadv, dayadv, hrsadv, minadv};
    endfunction

    task automatic check_model();
        logic [9:0] got, exp;
        logic [4:0] ev;
        ev  = (m_pulse >= 0) ? (5'b00001 << m_pulse) : 5'b00000;
        got = {field, timeset, alarmset, dut_adv()};
        exp = {3'(m_st), (m_st >= 1 && m_st <= 5), (m_st >= 6), ev};
        check("model", int'(got), int'(exp));
    endtask

    task automatic cyc();
        logic [4:0] a;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_model();
        a = dut_adv();
        for (int i = 0; i < 5; i++) if (a[i]) cnt[i]++;
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 5; i++) cnt[i] = 0;
    endtask

    task automatic do_reset();
        tick = 0; mode_btn = 0; adv_btn = 0;
        rst_n = 0;
        m_reset();
        repeat (2) cyc();
        #2 rst_n = 1;
        repeat (8) cyc();
    endtask

    task automatic press_mode();
        mode_btn = 1;
        repeat (2) cyc();
        mode_btn = 0;
        repeat (6) cyc();
    endtask

    task automatic do_tick();
        repeat (6) cyc();
        tick = 1;
        cyc();
        tick = 0;
    endtask

    // Adv press whose event edge coincides with a tick edge.
    task automatic adv_on_tick();
        repeat (6) cyc();
        adv_btn = 1;
        repeat (3) cyc();
        tick = 1;
        cyc();
        tick = 0;
    endtask

    initial begin
        int sum, md;
        logic [4:0] gm;
        int rep_exp [5] = '{1, 1, 2, 3, 4};

        vecs[0] = '{0, 0, 1'b0, 1'b0, 5'b00000};
        vecs[1] = '{1, 1, 1'b1, 1'b0, 5'b00001};
        vecs[2] = '{2, 2, 1'b1, 1'b0, 5'b00010};
        vecs[3] = '{3, 3, 1'b1, 1'b0, 5'b00100};
        vecs[4] = '{4, 4, 1'b1, 1'b0, 5'b01000};
        vecs[5] = '{5, 5, 1'b1, 1'b0, 5'b10000};
        vecs[6] = '{6, 6, 1'b0, 1'b1, 5'b00001};
        vecs[7] = '{7, 7, 1'b0, 1'b1, 5'b00010};

        m_reset();
        clr_cnt();
        do_reset();
        check("reset_field", int'(field), 0);
        check("reset_levels", int'({timeset, alarmset, dut_adv()}), 0);

        // Mode cycling with 3-edge latency
        for (int i = 0; i < 8; i++) begin
            mode_btn = 1;
            repeat (3) cyc();
            check("mode_lat_pre", int'(field), i);
            cyc();
            check("mode_lat_post", int'(field), (i + 1) % 8);
            check("mode_timeset", int'(timeset), ((i + 1) >= 1 && (i + 1) <= 5) ? 1 : 0);
            check("mode_alarmset", int'(alarmset), ((i + 1) >= 6 && (i + 1) <= 7) ? 1 : 0);
            mode_btn = 0;
            repeat (4) cyc();
        end

        // Vector table: one Adv press in every state
        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int k = 0; k < vecs[v].n_mode; k++) press_mode();
            check("vec_field", int'(field), vecs[v].fld);
            check("vec_timeset", int'(timeset), int'(vecs[v].ts));
            check("vec_alarmset", int'(alarmset), int'(vecs[v].as));
            clr_cnt();
            adv_btn = 1;
            repeat (2) cyc();
            adv_btn = 0;
            repeat (8) cyc();
            sum = 0;
            for (int i = 0; i < 5; i++) begin
                gm[i] = (cnt[i] > 0);
                sum += cnt[i];
            end
            check("vec_adv_mask", int'(gm), int'(vecs[v].mask));
            check("vec_adv_width", sum, $countones(vecs[v].mask));
        end

        // Single advance latency in SET_DATE
        do_reset();
        repeat (4) press_mode();
        adv_btn = 1;
        cyc();
        check("date_edge0", int'(dut_adv()), 0);
        repeat (2) cyc();
        check("date_edge2", int'(dut_adv()), 0);
        cyc();
        check("date_edge3", int'(dut_adv()), 5'b01000);
        cyc();
        check("date_edge4", int'(dut_adv()), 0);
        adv_btn = 0;
        repeat (6) cyc();

        // Reset mid-SET_HRS with a pulse in flight and Adv held
        do_reset();
        repeat (2) press_mode();
        adv_btn = 1;
        repeat (4) cyc();
        check("rst_inflight_pre", int'(hrsadv), 1);
        #2 rst_n = 0;
        m_reset();
        #1;
        check("rst_async_field", int'(field), 0);
        check("rst_async_outs", int'({timeset, alarmset, dut_adv()}), 0);
        repeat (3) cyc();
        #2 rst_n = 1;
        clr_cnt();
        repeat (10) cyc();
        press_mode();
        repeat (10) cyc();
        check("rst_held_field", int'(field), 1);
        check("rst_held_nopulse", cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4], 0);
        adv_btn = 0;
        repeat (4) cyc();
        adv_btn = 1;
        repeat (6) cyc();
        adv_btn = 0;
        check("rst_repress_pulse", cnt[0], 1);

        // Auto-repeat in SET_MIN
        do_reset();
        press_mode();
        clr_cnt();
        adv_btn = 1;
        repeat (6) cyc();
        check("rep_press", cnt[0], 1);
        for (int t = 0; t < 5; t++) begin
            do_tick();
            check("rep_count", cnt[0], rep_exp[t]);
            check("rep_now", int'(minadv), (t >= 2) ? 1 : 0);
        end
        adv_btn = 0;
        repeat (20) do_tick();
        check("rep_after_release", cnt[0], 4);
        check("rep_other_advs", cnt[1] + cnt[2] + cnt[3] + cnt[4], 0);

        // Timeout from ALM_HRS
        do_reset();
        repeat (7) press_mode();
        for (int t = 1; t <= 10; t++) begin
            do_tick();
            check("to_field", int'(field), (t < 10) ? 7 : 0);
        end

        // Adv press at tick 9 restarts the timeout
        do_reset();
        repeat (7) press_mode();
        repeat (8) do_tick();
        adv_on_tick();
        check("to9_hrsadv", int'(hrsadv), 1);
        check("to9_field", int'(field), 7);
        adv_btn = 0;
        for (int t = 10; t <= 19; t++) begin
            do_tick();
            check("to19_field", int'(field), (t < 19) ? 7 : 0);
        end

        // Adv press on the timeout tick
        do_reset();
        repeat (7) press_mode();
        repeat (9) do_tick();
        adv_on_tick();
        check("toadv_hrsadv", int'(hrsadv), 1);
        check("toadv_field", int'(field), 7);
        adv_btn = 0;
        repeat (6) cyc();
        check("toadv_stay", int'(field), 7);

        // Mode and Adv on the same edge in SET_MIN
        do_reset();
        press_mode();
        clr_cnt();
        mode_btn = 1;
        adv_btn = 1;
        repeat (4) cyc();
        check("simul_field", int'(field), 2);
        mode_btn = 0;
        adv_btn = 0;
        repeat (8) cyc();
        check("simul_nopulse", cnt[0] + cnt[1], 0);

        // Randomized run
        do_reset();
        for (int seg = 0; seg < 4; seg++) begin
            md = (seg == 0) ? 10 : (seg == 1) ? 40 : (seg == 2) ? 300 : 25;
            for (int c = 0; c < 1000; c++) begin
                tick = !tick && ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, md - 1) == 0) mode_btn = ~mode_btn;
                if ($urandom_range(0, 7) == 0) adv_btn = ~adv_btn;
                cyc();
            end
            if (seg == 1) begin
                #2 rst_n = 0;
                m_reset();
                repeat (2) cyc();
                #2 rst_n = 1;
            end
        end
        tick = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
